// File: rtl/lzw_pattern_gen.sv
// Character-stream source for the LZW compressor input. Produces a programmable
// number of 8-bit characters (alphabet, constant, LFSR or cyclic) followed by
// the end-of-file code, over a valid/ready byte interface.
//
// state   | meaning
// --------+----------------------------------------------------------------
// IDLE    | waiting for start; outputs quiet
// SEND    | presenting data characters, char_cnt counts accepted ones
// EOF     | presenting the terminator byte
// DONE    | terminator accepted; done pulses, busy drops on exit
module lzw_pattern_gen #(
    parameter int          LEN_W     = 12,
    parameter logic [7:0]  EOF_CODE  = 8'h0D,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter logic [7:0]  SUB_CHAR  = 8'h20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [1:0]       i_mode,
    input  logic [LEN_W-1:0] i_length,
    input  logic [7:0]       i_base_char,
    input  logic [3:0]       i_period,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [LEN_W-1:0] o_char_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_EOF  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_mode, w_mode_nxt;
    logic [LEN_W-1:0] r_len, w_len_nxt;
    logic [7:0]       r_base, w_base_nxt;
    logic [3:0]       r_period, w_period_nxt;
    logic [7:0]       r_alpha, w_alpha_nxt;
    logic [3:0]       r_idx, w_idx_nxt;
    logic [7:0]       r_lfsr, w_lfsr_nxt;
    logic [7:0]       r_tx_data, w_tx_data_nxt;
    logic             r_tx_valid, w_tx_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic [LEN_W-1:0] r_char_cnt, w_char_cnt_nxt;

    logic             w_transfer;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [7:0]       w_alpha_step;
    logic [3:0]       w_idx_step;
    logic [7:0]       w_lfsr_step;

    // Alphabet walk: A..Z, a..z, wrapping back to A; anything else just counts up.
    function automatic logic [7:0] f_alpha_next(input logic [7:0] c);
        if (c == 8'h5A)
            return 8'h61;
        else if (c == 8'h7A)
            return 8'h41;
        else
            return c + 8'd1;
    endfunction

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting left.
    function automatic logic [7:0] f_lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] f_char(input logic [1:0] m, input logic [7:0] base,
                                          input logic [7:0] alpha, input logic [3:0] idx,
                                          input logic [7:0] lfsr);
        case (m)
            2'd0:    return alpha;
            2'd1:    return base;
            2'd2:    return {2'b01, lfsr[5:0]};
            default: return base + {4'h0, idx};
        endcase
    endfunction

    // The terminator byte must never appear as data.
    function automatic logic [7:0] f_sub(input logic [7:0] c);
        return (c == EOF_CODE) ? SUB_CHAR : c;
    endfunction

    assign w_transfer   = r_tx_valid & i_tx_ready;
    assign w_cnt_inc    = r_char_cnt + CNT_ONE;
    assign w_alpha_step = f_alpha_next(r_alpha);
    assign w_idx_step   = ((r_idx + 4'd1) == r_period) ? 4'd0 : (r_idx + 4'd1);
    assign w_lfsr_step  = f_lfsr_next(r_lfsr);

    // Next-state and next-output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_len_nxt      = r_len;
        w_base_nxt     = r_base;
        w_period_nxt   = r_period;
        w_alpha_nxt    = r_alpha;
        w_idx_nxt      = r_idx;
        w_lfsr_nxt     = r_lfsr;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_char_cnt_nxt = r_char_cnt;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_mode_nxt     = i_mode;
                    w_len_nxt      = i_length;
                    w_base_nxt     = i_base_char;
                    w_period_nxt   = (i_period == 4'd0) ? 4'd1 : i_period;
                    w_alpha_nxt    = i_base_char;
                    w_idx_nxt      = 4'd0;
                    w_lfsr_nxt     = LFSR_SEED;
                    w_char_cnt_nxt = '0;
                    w_tx_valid_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    if (i_length != '0) begin
                        w_state_nxt   = ST_SEND;
                        w_tx_data_nxt = f_sub(f_char(i_mode, i_base_char, i_base_char,
                                                     4'd0, LFSR_SEED));
                    end else begin
                        w_state_nxt   = ST_EOF;
                        w_tx_data_nxt = EOF_CODE;
                    end
                end
            end
            ST_SEND: begin
                if (w_transfer) begin
                    w_char_cnt_nxt = w_cnt_inc;
                    w_alpha_nxt    = w_alpha_step;
                    w_idx_nxt      = w_idx_step;
                    w_lfsr_nxt     = w_lfsr_step;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt   = ST_EOF;
                        w_tx_data_nxt = EOF_CODE;
                    end else begin
                        w_tx_data_nxt = f_sub(f_char(r_mode, r_base, w_alpha_step,
                                                     w_idx_step, w_lfsr_step));
                    end
                end
                // A same-edge transfer is still counted above before cancelling.
                if (i_abort) begin
                    w_state_nxt    = ST_IDLE;
                    w_tx_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                end
            end
            ST_EOF: begin
                if (i_abort) begin
                    w_state_nxt    = ST_IDLE;
                    w_tx_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                end else if (w_transfer) begin
                    w_state_nxt    = ST_DONE;
                    w_tx_valid_nxt = 1'b0;
                    w_done_nxt     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_mode     <= 2'd0;
            r_len      <= '0;
            r_base     <= 8'h00;
            r_period   <= 4'd1;
            r_alpha    <= 8'h00;
            r_idx      <= 4'd0;
            r_lfsr     <= LFSR_SEED;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_char_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mode     <= w_mode_nxt;
            r_len      <= w_len_nxt;
            r_base     <= w_base_nxt;
            r_period   <= w_period_nxt;
            r_alpha    <= w_alpha_nxt;
            r_idx      <= w_idx_nxt;
            r_lfsr     <= w_lfsr_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_char_cnt <= w_char_cnt_nxt;
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_char_cnt = r_char_cnt;

endmodule

// File: tb/tb_lzw_pattern_gen.sv
// Bench for lzw_pattern_gen: directed and randomized streams checked against a
// queue-based reference model built from the character-generation rules.
module tb_lzw_pattern_gen;

    localparam int LEN_W = 12;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [1:0]       mode;
    logic [LEN_W-1:0] length;
    logic [7:0]       base_char;
    logic [3:0]       period;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] char_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];

    lzw_pattern_gen #(.LEN_W(LEN_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_mode      (mode),
        .i_length    (length),
        .i_base_char (base_char),
        .i_period    (period),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_char_cnt  (char_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One LFSR step from the polynomial's tap exponents x^8, x^6, x^5, x^4.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        int   taps[4] = '{8, 6, 5, 4};
        logic fb = 1'b0;
        foreach (taps[i]) fb = fb ^ s[taps[i]-1];
        return {s[6:0], fb};
    endfunction

    task automatic build_exp(input logic [1:0] m, input int len, input logic [7:0] b,
                             input logic [3:0] p);
        logic [7:0] c  = b;
        logic [7:0] s  = 8'hA5;
        logic [7:0] ch;
        int         pe = (p == 4'd0) ? 1 : int'(p);
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            case (m)
                2'd0:    ch = c;
                2'd1:    ch = b;
                2'd2:    ch = {2'b01, s[5:0]};
                default: ch = b + 8'(k % pe);
            endcase
            if (ch == 8'h0D) ch = 8'h20;
            exp_q.push_back(ch);
            if (c == 8'h5A)      c = 8'h61;
            else if (c == 8'h7A) c = 8'h41;
            else                 c = c + 8'd1;
            s = lfsr_step(s);
        end
        exp_q.push_back(8'h0D);
    endtask

    // Launch a stream and check every accepted byte, stall stability, and the end pulse.
    task automatic run_stream(input logic [1:0] m, input int len, input logic [7:0] b,
                              input logic [3:0] p, input bit rnd);
        int         idx = 0;
        int         cyc = 0;
        int         budget = 4 * len + 50;
        bit         stalled = 1'b0;
        logic [7:0] prev = 8'h00;
        build_exp(m, len, b, p);
        @(posedge clk); #1;
        mode = m; length = LEN_W'(len); base_char = b; period = p;
        tx_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~m; base_char = ~b; length = '1;
        while (idx < exp_q.size() && cyc < budget) begin
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (!rnd) chk("valid_streaming", tx_valid, 1);
            if (stalled && tx_valid) chk("stall_hold", tx_data, prev);
            if (tx_valid && tx_ready) begin
                chk("byte", tx_data, exp_q[idx]);
                if (m == 2'd2 && idx < len) chk("lfsr_range", tx_data[7:6], 2'b01);
                idx++;
                stalled = 1'b0;
            end else if (tx_valid) begin
                stalled = 1'b1;
                prev    = tx_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("stream_complete", idx, exp_q.size());
        tx_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("valid_after_eof", tx_valid, 0);
        chk("char_cnt_final", char_cnt, len);
        @(negedge clk);
        chk("done_clears", done, 0);
        chk("busy_clears", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0; length = '0;
        base_char = 8'h00; period = 4'd0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", char_cnt, 0);
        rst_n = 1'b1;

        run_stream(2'd0, 52, 8'h41, 4'd0, 1'b0);
        run_stream(2'd1, 4095, 8'h61, 4'd0, 1'b1);
        run_stream(2'd3, 6, 8'h0B, 4'd4, 1'b0);
        run_stream(2'd2, 8, 8'($urandom), 4'd0, 1'b0);
        for (int r = 0; r < 4; r++)
            run_stream(2'($urandom_range(0, 3)), int'($urandom_range(1, 40)),
                       8'($urandom), 4'($urandom), 1'b1);

        // Zero-length stream, with a start attempt while busy.
        @(posedge clk); #1;
        mode = 2'd0; length = '0; base_char = 8'h41; tx_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("len0_valid", tx_valid, 1);
        chk("len0_data", tx_data, 8'h0D);
        chk("len0_busy", busy, 1);
        @(posedge clk); #1;
        mode = 2'd1; length = 12'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_start_ignored", tx_data, 8'h0D);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        chk("len0_done", done, 1);
        chk("len0_cnt", char_cnt, 0);
        chk("len0_valid_off", tx_valid, 0);
        repeat (3) @(negedge clk);
        chk("len0_no_restart", tx_valid, 0);
        chk("len0_idle_busy", busy, 0);

        // Abort on the edge of the third transfer.
        @(posedge clk); #1;
        mode = 2'd0; length = 12'd10; base_char = 8'h41; tx_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        chk("abort_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cnt", char_cnt, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end

        // Asynchronous reset in the middle of a stream, then a clean restart.
        @(posedge clk); #1;
        mode = 2'd2; length = 12'd20; tx_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", tx_valid, 0);
        chk("arst_data", tx_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt", char_cnt, 0);
        chk("arst_done", done, 0);
        tx_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_stream(2'd2, 8, 8'h00, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lzw_pattern_gen.md
Name: lzw_pattern_gen

Overview:
- Synthesizable parametrised character-stream source feeding the LZW compressor input in place of the serial receive path, for built-in self-test and bench stimulus.
- Emits a programmable-length stream of 8-bit characters in one of four modes, followed by the end-of-file code, over a valid/ready byte interface.
- Covers the no-compression alphabet case, plus modes the alphabet case cannot produce: constant (maximum compression), cyclic pattern, and pseudo-random.

Parameters:
- LEN_W, 12, width of length and char_cnt; max stream length is 2^LEN_W-1 characters (4095 for files under 4K).
- EOF_CODE, 8'h0D, terminator byte appended after the last character.
- LFSR_SEED, 8'hA5, LFSR load value at start; must be nonzero.
- SUB_CHAR, 8'h20, replacement byte for any generated character equal to EOF_CODE.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a stream; sampled only in IDLE.
- abort  in  1  synchronous stream cancel.
- mode  in  2  0 alphabet, 1 constant, 2 LFSR, 3 cyclic.
- length  in  LEN_W  number of data characters before EOF_CODE.
- base_char  in  8  first character (modes 0, 1, 3).
- period  in  4  cycle length for mode 3; 0 is treated as 1.
- tx_data  out  8  current byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  downstream accepts byte.
- busy  out  1  stream in progress.
- done  out  1  one-cycle pulse after EOF_CODE is accepted.
- char_cnt  out  LEN_W  data characters accepted so far, excluding EOF.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; tx_valid=0, tx_data=0, busy=0, done=0, char_cnt=0, LFSR=LFSR_SEED. Outputs clear immediately, not at the next clock.
- States: IDLE, SEND, EOF, DONE.
- IDLE + start: latch mode, length, base_char and period; clear char_cnt; load LFSR_SEED.
  - If length≠0, go to SEND with the first character registered on tx_data.
  - If length=0, go to EOF with tx_data=EOF_CODE.
  - tx_valid and busy assert the cycle after start.
- Transfer occurs on a clock edge where tx_valid & tx_ready. tx_data is held stable while tx_valid=1 and tx_ready=0.
- A new byte is presented the cycle after each transfer, so one byte per clock is sustained while tx_ready stays high.
- SEND: each transfer increments char_cnt and computes the next character. When the transfer makes char_cnt equal length, the next state is EOF with tx_data=EOF_CODE.
- EOF: on transfer go to DONE with tx_valid=0. DONE pulses done=1 for one cycle, clears busy and returns to IDLE.
- Start is ignored in every state except IDLE.
- Character generation; index k counts from 0:
  - Mode 0 (alphabet): c0=base_char, then increment. After 0x5A go to 0x61; after 0x7A go to 0x41. Other values increment by 1 modulo 256.
  - Mode 1 (constant): every character equals base_char.
  - Mode 2 (LFSR): 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, shifted once per transfer. Character = {2'b01, lfsr[5:0]}, range 0x40–0x7F; base_char is ignored.
  - Mode 3 (cyclic): character = base_char + (k mod period), 8-bit wrap.
- Any generated character equal to EOF_CODE is sent as SUB_CHAR, so EOF_CODE appears only as the terminator.
- Abort, when high in SEND or EOF: next cycle tx_valid=0, busy=0, state IDLE. No EOF is sent, done is not pulsed, and char_cnt is held. Abort in IDLE or DONE has no effect.
- Abort and a transfer on the same edge: the transfer counts, then the abort applies.
- Modes and inputs are latched at start; changes during the stream are ignored.

Test Plan:
- mode=0, base=0x41, length=52, tx_ready=1 -> bytes 0x41..0x5A, 0x61..0x7A, then 0x0D; 53 consecutive valid cycles; char_cnt=52; one done pulse.
- mode=1, base=0x61, length=4095, random tx_ready -> 4095×0x61 then 0x0D; tx_data stable through every stall; char_cnt=0xFFF.
- mode=3, base=0x0B, period=4, length=6 -> 0x0B, 0x0C, 0x20 (substituted for 0x0D), 0x0E, 0x0B, 0x0C, 0x0D.
- mode=2, length=8 -> first byte {01, 0xA5[5:0]}=0x65; sequence matches the LFSR reference model; all bytes in 0x40–0x7F; then EOF.
- length=0 -> only 0x0D is sent, then done; start pulsed while busy has no effect.
- Abort after 3 transfers -> tx_valid low the next cycle, no 0x0D, no done, char_cnt=3. Reset low mid-stream -> all outputs 0 asynchronously; a new start after reset restarts cleanly.
